// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI read arbiter slice.
package axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    ERR  = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Index width for n masters; a single master still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_read_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo NM.
module rr_pick
  import axi_pkg::*;
#(
  parameter int NM = 3,
  parameter int IW = 2
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  int pos;

  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int k = 0; k < NM; k++) begin
      pos = (int'(ptr) + k) % NM;
      if (!any && req[pos]) begin
        any = 1'b1;
        idx = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one downstream AXI read channel among NM masters, one burst at a time,
// answering decode misses locally with DECERR beats.
//
// state | meaning
// IDLE  | no burst owned; grant first requester at/after rr_ptr and latch its AR
// ADDR  | present latched AR downstream, or divert to ERR on a decode miss
// DATA  | pass R beats from the slave to the granted master until s_rlast
// ERR   | generate ARLEN+1 DECERR beats to the granted master
module axi_read_arbiter
  import axi_pkg::*;
#(
  parameter  int NM     = 3,
  parameter  int ID_W   = 4,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  parameter  int LEN_W  = 4,
  localparam int IW     = idx_w(NM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NM-1:0]        m_arvalid,
  output logic [NM-1:0]        m_arready,
  input  logic [NM*ID_W-1:0]   m_arid,
  input  logic [NM*ADDR_W-1:0] m_araddr,
  input  logic [NM*LEN_W-1:0]  m_arlen,
  input  logic [NM*3-1:0]      m_arsize,
  input  logic [NM*2-1:0]      m_arburst,
  output logic [NM-1:0]        m_rvalid,
  input  logic [NM-1:0]        m_rready,
  output logic [ID_W-1:0]      m_rid,
  output logic [DATA_W-1:0]    m_rdata,
  output logic [1:0]           m_rresp,
  output logic                 m_rlast,
  output logic                 s_arvalid,
  input  logic                 s_arready,
  output logic [ID_W+IW-1:0]   s_arid,
  output logic [ADDR_W-1:0]    s_araddr,
  output logic [LEN_W-1:0]     s_arlen,
  output logic [2:0]           s_arsize,
  output logic [1:0]           s_arburst,
  input  logic                 s_rvalid,
  output logic                 s_rready,
  input  logic [ID_W+IW-1:0]   s_rid,
  input  logic [DATA_W-1:0]    s_rdata,
  input  logic [1:0]           s_rresp,
  input  logic                 s_rlast,
  input  logic                 dec_err,
  output logic                 proto_err
);

  state_e            state, state_nxt;
  logic [IW-1:0]     gnt, rr_ptr, nxt_ptr, pick_idx;
  logic              pick_any;
  logic [ID_W-1:0]   ar_id;
  logic [ADDR_W-1:0] ar_addr;
  logic [LEN_W-1:0]  ar_len;
  logic [2:0]        ar_size;
  logic [1:0]        ar_burst;
  logic [LEN_W-1:0]  beat_cnt;
  logic              last_beat;
  logic              gnt_rready;
  logic              unused_rid_hi;

  rr_pick #(.NM(NM), .IW(IW)) u_rr_pick (
    .req (m_arvalid),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign last_beat     = (beat_cnt == ar_len);
  assign gnt_rready    = m_rready[gnt];
  assign nxt_ptr       = (gnt == IW'(NM - 1)) ? '0 : gnt + 1'b1;
  // Upper RID bits carry our own master index; masters only see their ARID.
  assign unused_rid_hi = ^s_rid[ID_W+IW-1:ID_W];

  assign s_arid    = {gnt, ar_id};
  assign s_araddr  = ar_addr;
  assign s_arlen   = ar_len;
  assign s_arsize  = ar_size;
  assign s_arburst = ar_burst;

  always_comb begin
    state_nxt = state;
    m_arready = '0;
    m_rvalid  = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    m_rid     = '0;
    m_rdata   = '0;
    m_rresp   = RESP_OKAY;
    m_rlast   = 1'b0;
    case (state)
      IDLE: begin
        // Gated so no master sees an accept while reset is held.
        if (pick_any && !rst) begin
          m_arready[pick_idx] = 1'b1;
          state_nxt           = ADDR;
        end
      end
      ADDR: begin
        if (dec_err) begin
          state_nxt = ERR;
        end else begin
          s_arvalid = 1'b1;
          if (s_arready) state_nxt = DATA;
        end
      end
      DATA: begin
        m_rvalid[gnt] = s_rvalid;
        s_rready      = gnt_rready;
        m_rid         = s_rid[ID_W-1:0];
        m_rdata       = s_rdata;
        m_rresp       = s_rresp;
        m_rlast       = s_rlast;
        if (s_rvalid && gnt_rready && s_rlast) state_nxt = IDLE;
      end
      ERR: begin
        m_rvalid[gnt] = 1'b1;
        m_rid         = ar_id;
        m_rresp       = RESP_DECERR;
        m_rlast       = last_beat;
        if (gnt_rready && last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      rr_ptr    <= '0;
      ar_id     <= '0;
      ar_addr   <= '0;
      ar_len    <= '0;
      ar_size   <= '0;
      ar_burst  <= '0;
      beat_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt      <= pick_idx;
            ar_id    <= m_arid[int'(pick_idx)*ID_W +: ID_W];
            ar_addr  <= m_araddr[int'(pick_idx)*ADDR_W +: ADDR_W];
            ar_len   <= m_arlen[int'(pick_idx)*LEN_W +: LEN_W];
            ar_size  <= m_arsize[int'(pick_idx)*3 +: 3];
            ar_burst <= m_arburst[int'(pick_idx)*2 +: 2];
          end
        end
        ADDR: beat_cnt <= '0;
        DATA: begin
          if (s_rvalid && gnt_rready) begin
            beat_cnt <= beat_cnt + 1'b1;
            // Flag a misplaced RLAST but still let the slave end the burst.
            if (s_rlast != last_beat) proto_err <= 1'b1;
            if (s_rlast) rr_ptr <= nxt_ptr;
          end
        end
        ERR: begin
          if (gnt_rready) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat) rr_ptr <= nxt_ptr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomized bench for axi_read_arbiter against a transaction-level model of
// grants, address forwarding, beat delivery and RLAST protocol errors.
module tb_axi_read_arbiter;
  import axi_pkg::*;

  localparam int NM = 3, ID_W = 4, ADDR_W = 32, DATA_W = 32, LEN_W = 4, IW = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic [NM-1:0]        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [NM*ID_W-1:0]   m_arid;
  logic [NM*ADDR_W-1:0] m_araddr;
  logic [NM*LEN_W-1:0]  m_arlen;
  logic [NM*3-1:0]      m_arsize;
  logic [NM*2-1:0]      m_arburst;
  logic [ID_W-1:0]      m_rid;
  logic [DATA_W-1:0]    m_rdata;
  logic [1:0]           m_rresp;
  logic                 m_rlast;
  logic                 s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [ID_W+IW-1:0]   s_arid, s_rid;
  logic [ADDR_W-1:0]    s_araddr;
  logic [LEN_W-1:0]     s_arlen;
  logic [2:0]           s_arsize;
  logic [1:0]           s_arburst, s_rresp;
  logic [DATA_W-1:0]    s_rdata;
  logic                 dec_err, proto_err;

  axi_read_arbiter #(.NM(NM), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .dec_err(dec_err), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Address map stub: only 0x0001_0000..0x0FFF_FFFF decodes to a slave.
  function automatic logic addr_miss(input logic [31:0] a);
    return (a[31:28] != 4'h0) || (a[27:16] == 12'h000);
  endfunction
  assign dec_err = addr_miss(s_araddr);

  // master request side
  logic       req_pend [NM];
  logic [3:0] req_id   [NM];
  logic [31:0] req_addr[NM];
  logic [3:0] req_len  [NM];
  logic [2:0] req_size [NM];
  logic [1:0] req_burst[NM];

  always_comb begin
    m_arvalid = '0; m_arid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
    for (int i = 0; i < NM; i++) begin
      m_arvalid[i]            = req_pend[i];
      m_arid[i*ID_W +: ID_W]  = req_id[i];
      m_araddr[i*32 +: 32]    = req_addr[i];
      m_arlen[i*4 +: 4]       = req_len[i];
      m_arsize[i*3 +: 3]      = req_size[i];
      m_arburst[i*2 +: 2]     = req_burst[i];
    end
  end

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [5:0]  id;
  } beat_t;
  beat_t sq[$];

  int n_checks = 0, n_errors = 0;
  bit gen_on = 0, rnd_ar = 0, rnd_rv = 0, rnd_rr = 0;
  int stall = 0, inject_at = -1, sarv_cnt = 0;
  int grant_log[$];

  // reference model state (transaction level)
  bit busy = 0, addr_pend = 0, derr = 0, exp_proto = 0, cur_inj = 0;
  int g_m = 0, beat = 0, ptr = 0, bursts_done = 0, cur_inj_at = 0;
  logic [3:0] cur_id, cur_len;
  logic [31:0] cur_addr;
  logic [2:0] cur_size;
  logic [1:0] cur_burst;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic post_req(input int m, input logic [3:0] id, input logic [31:0] a, input logic [3:0] len);
    req_pend[m] = 1'b1; req_id[m] = id; req_addr[m] = a; req_len[m] = len;
    req_size[m] = 3'd2; req_burst[m] = BURST_INCR;
  endtask

  task automatic rand_req(input int m);
    logic [31:0] a;
    if ($urandom_range(0, 4) == 0) a = {16'h0000, 16'($urandom)};
    else a = {4'h0, 12'($urandom_range(1, 4095)), 16'($urandom)};
    post_req(m, 4'($urandom), a, 4'($urandom_range(0, 7)));
    req_burst[m] = 2'($urandom_range(0, 2));
    req_size[m]  = 3'($urandom_range(0, 2));
  endtask

  task automatic step();
    logic [NM-1:0] exp_ar, exp_rv, rr_s;
    logic sarr_s, srv_s;
    int pk, nb;
    bit done;
    beat_t f;
    @(negedge clk);
    if (gen_on)
      for (int i = 0; i < NM; i++)
        if (!req_pend[i] && $urandom_range(0, 5) == 0) rand_req(i);
    s_arready = rnd_ar ? 1'($urandom_range(0, 1)) : 1'b1;
    if (sq.size() > 0) begin
      s_rvalid = rnd_rv ? 1'($urandom_range(0, 1)) : 1'b1;
      s_rid = sq[0].id; s_rdata = sq[0].data; s_rresp = sq[0].resp; s_rlast = sq[0].last;
    end else begin
      s_rvalid = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0;
    end
    if (stall > 0) begin
      m_rready = '0;
      stall--;
    end else begin
      for (int i = 0; i < NM; i++) m_rready[i] = rnd_rr ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    #1;
    exp_ar = '0;
    pk = -1;
    if (!busy)
      for (int k = 0; k < NM; k++)
        if (pk < 0 && req_pend[(ptr + k) % NM]) pk = (ptr + k) % NM;
    if (pk >= 0) exp_ar[pk] = 1'b1;
    check("m_arready", m_arready, exp_ar);
    check("s_arvalid", s_arvalid, busy && addr_pend && !derr);
    if (s_arvalid)
      check("s_ar_payload", {s_arid, s_araddr, s_arlen, s_arsize, s_arburst},
            {IW'(g_m), cur_id, cur_addr, cur_len, cur_size, cur_burst});
    exp_rv = '0;
    if (busy && !addr_pend && (derr || s_rvalid)) exp_rv[g_m] = 1'b1;
    check("m_rvalid", m_rvalid, exp_rv);
    check("s_rready", s_rready, busy && !addr_pend && !derr && m_rready[g_m]);
    if (exp_rv != '0) begin
      if (derr)
        check("err_beat", {m_rid, m_rdata, m_rresp, m_rlast},
              {cur_id, 32'h0, RESP_DECERR, 1'(beat == int'(cur_len))});
      else
        check("r_beat", {m_rid, m_rdata, m_rresp, m_rlast},
              {cur_id, sq[0].data, sq[0].resp, sq[0].last});
    end
    check("proto_err", proto_err, exp_proto);
    for (int i = 0; i < NM; i++) if (m_arready[i]) grant_log.push_back(i);
    if (s_arvalid) sarv_cnt++;
    sarr_s = s_arready; srv_s = s_rvalid; rr_s = m_rready;
    @(posedge clk);
    #1;
    done = 0;
    if (busy) begin
      if (addr_pend) begin
        if (derr) addr_pend = 0;
        else if (sarr_s) begin
          addr_pend = 0;
          nb = cur_inj ? cur_inj_at + 1 : int'(cur_len) + 1;
          for (int b = 0; b < nb; b++) begin
            f.data = $urandom;
            f.resp = (rnd_rv && $urandom_range(0, 7) == 0) ? RESP_SLVERR : RESP_OKAY;
            f.last = (b == nb - 1);
            f.id   = {IW'(g_m), cur_id};
            sq.push_back(f);
          end
        end
      end else if (rr_s[g_m] && (derr || srv_s)) begin
        if (derr) begin
          done = (beat == int'(cur_len));
        end else begin
          f = sq.pop_front();
          if (f.last != (beat == int'(cur_len))) exp_proto = 1;
          done = f.last;
        end
        beat++;
        if (done) begin
          if (!cur_inj) check("burst_beats", beat, int'(cur_len) + 1);
          busy = 0;
          ptr = (g_m + 1) % NM;
          bursts_done++;
        end
      end
    end else if (pk >= 0) begin
      busy = 1; addr_pend = 1; beat = 0; g_m = pk;
      cur_id = req_id[pk]; cur_addr = req_addr[pk]; cur_len = req_len[pk];
      cur_size = req_size[pk]; cur_burst = req_burst[pk];
      derr = addr_miss(req_addr[pk]);
      cur_inj = (inject_at >= 0); cur_inj_at = inject_at; inject_at = -1;
      req_pend[pk] = 1'b0;
    end
  endtask

  task automatic run_bursts(input int n, input int maxc);
    int target, c;
    target = bursts_done + n;
    c = 0;
    while (bursts_done < target && c < maxc) begin step(); c++; end
    check("burst_timeout", bursts_done, target);
  endtask

  task automatic wait_beat(input int b, input int maxc);
    int c;
    c = 0;
    while (!(busy && !addr_pend && beat >= b) && c < maxc) begin step(); c++; end
    check("beat_timeout", (busy && !addr_pend && beat >= b), 1);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    rst = 1'b1;
    busy = 0; addr_pend = 0; derr = 0; ptr = 0; exp_proto = 0;
    sq.delete();
    for (int i = 0; i < NM; i++) req_pend[i] = 1'b0;
    post_req(2, 4'hC, 32'h0005_0000, 4'd1);
    s_rvalid = 1'b1; s_rlast = 1'b1; m_rready = '1;
    #1;
    check("rst_mid_outs", {m_arready, m_rvalid, s_arvalid, s_rready, proto_err}, '0);
    @(posedge clk);
    #1;
    check("rst_hold_outs", {m_arready, m_rvalid, s_arvalid, s_rready, proto_err}, '0);
    rst = 1'b0;
    s_rvalid = 1'b0; s_rlast = 1'b0;
  endtask

  initial begin
    int base, s0, gl;
    int order[4] = '{0, 1, 2, 0};
    for (int i = 0; i < NM; i++) begin
      req_pend[i] = 0; req_id[i] = 0; req_addr[i] = 0; req_len[i] = 0; req_size[i] = 0; req_burst[i] = 0;
    end
    s_arready = 0; s_rvalid = 0; s_rid = 0; s_rdata = 0; s_rresp = 0; s_rlast = 0; m_rready = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outs", {m_arready, m_rvalid, s_arvalid, s_rready, proto_err, m_rlast}, '0);
    check("reset_ar_payload", {s_arid, s_araddr, s_arlen}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single 4-beat OKAY burst from M0
    post_req(0, 4'h5, 32'h0001_0000, 4'd3);
    run_bursts(1, 60);
    // rr_ptr now 1: M2 beats M0 when both request together
    post_req(0, 4'h1, 32'h0001_1000, 4'd0);
    post_req(2, 4'h2, 32'h0001_2000, 4'd0);
    run_bursts(2, 60);
    check("ptr_after_m0_grant", grant_log.size() >= 3 ? grant_log[1] : -1, 2);
    check("ptr_after_m0_next", grant_log.size() >= 3 ? grant_log[2] : -1, 0);
    post_req(2, 4'h3, 32'h0001_3000, 4'd1);
    run_bursts(1, 60);

    // simultaneous requests with rr_ptr=0, then M0 again
    base = grant_log.size();
    post_req(0, 4'h4, 32'h0002_0000, 4'd2);
    post_req(1, 4'h6, 32'h0002_1000, 4'd1);
    post_req(2, 4'h8, 32'h0002_2000, 4'd3);
    run_bursts(3, 100);
    post_req(0, 4'hB, 32'h0002_3000, 4'd0);
    post_req(2, 4'hD, 32'h0002_4000, 4'd0);
    run_bursts(1, 60);
    for (int k = 0; k < 4; k++)
      check($sformatf("rr_order%0d", k), (grant_log.size() > base + k) ? grant_log[base + k] : -1, order[k]);
    run_bursts(1, 60);

    // decode miss answered locally
    s0 = sarv_cnt;
    post_req(1, 4'h9, 32'h0000_4000, 4'd1);
    run_bursts(1, 60);
    check("decerr_no_sarvalid", sarv_cnt - s0, 0);

    // early RLAST from slave
    inject_at = 1;
    post_req(2, 4'h3, 32'h0002_0000, 4'd2);
    run_bursts(1, 60);
    check("proto_err_set", proto_err, 1);
    post_req(0, 4'h2, 32'h0003_0000, 4'd1);
    run_bursts(1, 60);
    check("proto_err_sticky", proto_err, 1);

    // master back-pressure mid-burst
    post_req(1, 4'hA, 32'h0003_0000, 4'd5);
    wait_beat(2, 60);
    stall = 3;
    run_bursts(1, 80);

    // randomized traffic
    gen_on = 1; rnd_ar = 1; rnd_rv = 1; rnd_rr = 1;
    repeat (3000) step();
    gen_on = 0;
    begin
      int c;
      c = 0;
      while ((busy || req_pend[0] || req_pend[1] || req_pend[2]) && c < 1000) begin step(); c++; end
      check("drain_timeout", busy || req_pend[0] || req_pend[1] || req_pend[2], 0);
    end
    rnd_ar = 0; rnd_rv = 0; rnd_rr = 0;

    // reset in the middle of a data burst
    post_req(0, 4'h7, 32'h0004_0000, 4'd7);
    wait_beat(2, 60);
    reset_mid();
    gl = grant_log.size();
    begin
      int c;
      c = 0;
      while (grant_log.size() == gl && c < 20) begin step(); c++; end
    end
    check("post_reset_grant", grant_log.size() > gl ? grant_log[gl] : -1, 2);
    run_bursts(1, 60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
